// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score_keeper block.
// The optional high-score feature is enabled with the SCORE_HISCORE_EN macro.
package score_pkg;

    // Game state: scoring is live in PLAY and frozen in OVER.
    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam int SCORE_W  = 8;
    localparam int PEND_W   = 9;
    localparam int PEND_SAT = 511;
    localparam int PTS_W    = 4;

    // Default raster geometry; V_ACTIVE is the first blanking line.
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Zero-extend a point value to the accumulator width.
    function automatic logic [PEND_W-1:0] widen_pts(input logic [PTS_W-1:0] pts);
        return {{(PEND_W-PTS_W){1'b0}}, pts};
    endfunction

endpackage

// File: rtl/score_keeper_sat_add.sv
// sat_add: unsigned adder of two W-bit operands that clamps the result at CEIL.
// The sum is formed one bit wider than the operands so the carry is never
// lost; OW may be narrower than W when CEIL is known to fit in OW bits.
module sat_add #(
    parameter int W    = 9,
    parameter int OW   = 9,
    parameter int CEIL = 511
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] y
);

    localparam logic [W:0] CEIL_X = (W+1)'(CEIL);

    logic [W:0] sum;

    // Full-width sum followed by a clamp to the ceiling.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        if (sum > CEIL_X) begin
            y = CEIL_X[OW-1:0];
        end else begin
            y = sum[OW-1:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: collects point events into a pending accumulator and folds
// them into the visible score once per frame, at the first pixel of
// COMMIT_LINE, so the overlay never sees a digit change mid-draw.
// Define SCORE_HISCORE_EN to add the hiscore output and register.
//
// Handshake: add_valid qualifies add_pts for exactly the cycle it is high;
// there is no ready, every add seen in PLAY is taken, adds in OVER are dropped.
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE   = 255,
    parameter int COMMIT_LINE = V_ACTIVE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic               add_valid,
    input  logic [PTS_W-1:0]   add_pts,
    input  logic               clear,
    input  logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic               frozen,
`ifdef SCORE_HISCORE_EN
    output logic               commit,
    output logic [SCORE_W-1:0] hiscore
`else
    output logic               commit
`endif
);

    state_t              state;
    state_t              state_next;

    logic [PEND_W-1:0]   pend;
    logic [PEND_W-1:0]   pend_sum;
    logic [PEND_W-1:0]   add_ext;
    logic [PEND_W-1:0]   commit_base;
    logic [SCORE_W-1:0]  commit_sum;
    logic                clr_pend;
    logic                commit_pt;
    logic                accept;

    // Commit point and add acceptance decode.
    always_comb begin
        commit_pt   = pixpulse && (hcount == 10'd0) && (vcount == 10'(COMMIT_LINE));
        accept      = add_valid && (state == PLAY);
        add_ext     = accept ? widen_pts(add_pts) : '0;
        // After a clear the next commit loads pend alone rather than adding.
        commit_base = clr_pend ? '0 : {1'b0, score};
    end

    // Accumulate path: pend plus the accepted add, clamped at PEND_SAT.
    sat_add #(
        .W    (PEND_W),
        .OW   (PEND_W),
        .CEIL (PEND_SAT)
    ) u_pend_add (
        .a (pend),
        .b (add_ext),
        .y (pend_sum)
    );

    // Commit path: (score or zero) plus pend, clamped at MAX_SCORE.
    sat_add #(
        .W    (PEND_W),
        .OW   (SCORE_W),
        .CEIL (MAX_SCORE)
    ) u_commit_add (
        .a (commit_base),
        .b (pend),
        .y (commit_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PLAY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: clear always returns to PLAY and wins over game_over.
    always_comb begin
        state_next = state;
        case (state)
            PLAY: begin
                if (!clear && game_over) begin
                    state_next = OVER;
                end
            end
            OVER: begin
                if (clear) begin
                    state_next = PLAY;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    // Pending accumulator, clear flag, committed score and status outputs.
    // At a commit or a clear, pend restarts from the same-cycle add so no
    // point is lost or counted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            clr_pend <= 1'b0;
            score    <= '0;
            commit   <= 1'b0;
            frozen   <= 1'b0;
        end else begin
            commit <= commit_pt;
            frozen <= (state == OVER);
            if (commit_pt) begin
                score <= commit_sum;
            end
            if (commit_pt || clear) begin
                pend <= add_ext;
            end else begin
                pend <= pend_sum;
            end
            if (clear) begin
                clr_pend <= 1'b1;
            end else if (commit_pt) begin
                clr_pend <= 1'b0;
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    // High score tracks the largest committed score; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore <= '0;
        end else if (commit_pt && (commit_sum > hiscore)) begin
            hiscore <= commit_sum;
        end
    end
`endif

endmodule

// File: doc/score_keeper.md
# score_keeper

Accumulates point events from game logic into the 8-bit binary score that drives the 3-digit score overlay. Point events arrive asynchronously to the raster. The visible score is updated only once per frame, at a fixed blanking-line commit point, so a digit never changes mid-draw. The block sits directly upstream of the score overlay and shares its `hcount`/`vcount`/`pixpulse` raster timing.

## Interface
Parameters:
- `MAX_SCORE`, default 255: saturation ceiling of the score, 1..255.
- `COMMIT_LINE`, default 480: `vcount` value at which pending points are committed; must lie in vertical blanking.

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `pixpulse` in 1: 25 MHz pixel enable, one `clk` in four.
- `hcount` in 10: current raster x.
- `vcount` in 10: current raster y.
- `add_valid` in 1: qualifies `add_pts` for one `clk` cycle.
- `add_pts` in 4: points to add, 0..15.
- `clear` in 1: one-cycle request to zero the score.
- `game_over` in 1: one-cycle request to freeze scoring.
- `score` out 8: committed score, stable for a whole frame.
- `frozen` out 1: high while in state OVER.
- `commit` out 1: one-`clk` pulse, registered together with each score update.
- `hiscore` out 8: only present with `SCORE_HISCORE_EN`.

## Operation
- State machine with two states, PLAY and OVER; reset state is PLAY.
  - PLAY to OVER when `game_over`=1 and `clear`=0.
  - OVER to PLAY on `clear`=1.
  - `clear` wins over `game_over` in the same cycle.
- Pending accumulator `pend` is 9 bits and saturates at 511.
  - In PLAY, `add_valid`=1 adds `add_pts` to `pend`.
  - In OVER, adds are dropped.
  - `add_pts`=0 with `add_valid`=1 is a legal no-op.
- Commit point: a `clk` cycle with `pixpulse`=1, `hcount`=0 and `vcount`=`COMMIT_LINE`. At the commit point:
  - `score` becomes min(`score` + `pend`, `MAX_SCORE`), computed 9-bit wide; `score` never wraps.
  - `pend` is reloaded with the same-cycle add (if accepted), otherwise 0. No point is lost or double-counted.
  - `commit` pulses.
- `clear` handling:
  - Immediately zeroes `pend`. Adds accepted after `clear` in the same frame accumulate normally.
  - Sets the `clr_pend` flag. At the next commit, `score` is loaded with min(`pend`, `MAX_SCORE`) instead of the sum, then `clr_pend` is dropped.
  - `score` itself never changes outside a commit point.
- `clear` and `add_valid` in the same cycle: the clear zeroes `pend` first, then the add is accumulated, so `pend` = `add_pts`.
- The transition to OVER takes effect the next cycle. Points already in `pend` still commit at the next commit point.

## Timing
- Reset values: `score`=0, `pend`=0, `clr_pend`=0, state PLAY, `frozen`=0, `commit`=0, `hiscore`=0.
- `rst` is sampled on `clk` only. A reset mid-frame or at a commit point discards the pending points and any update.
- `score`, `frozen`, `commit` and `hiscore` are all registered.
- `score` changes exactly one `clk` after the commit cycle, once per frame. Worst-case latency from an add to the visible score is one frame plus one `clk`.
- `frozen` follows state with one-cycle latency.
- Adds are accepted on every `clk` cycle, independent of `pixpulse`. There is no backpressure.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds the `hiscore` port and register.
  - On every commit, `hiscore` <= max(`hiscore`, new `score`).
  - `clear` does not affect `hiscore`; only `rst` does.
- `SCORE_HISCORE_EN` undefined: the port and register are absent, and all other behaviour is identical.

## Structure
- Shared package `score_pkg` holds:
  - the state enum (PLAY, OVER);
  - the score width (8);
  - the pend width (9);
  - the pend saturation constant (511);
  - the default raster constants H_ACTIVE=640 and V_ACTIVE=480, used as the `COMMIT_LINE` default.
- One sub-module, `sat_add`: a parameterised-width unsigned adder with a saturation ceiling. It is instantiated twice, once for the `pend` accumulate and once for the commit sum.

## Test plan
- Reset, then three adds of 5 mid-frame:
  - `score` stays 0 until the commit;
  - `score`=15 one `clk` after the commit;
  - exactly one `commit` pulse.
- `score`=250 and `pend`=12 at the commit -> `score`=255. A further add of 9 -> `score` stays 255.
- An add of 7 in the exact commit cycle, with `pend`=3 -> `score` increases by 3 at this commit and by 7 at the next commit.
- `score`=40 and `pend`=6, then `clear` together with an add of 2 -> `score`=40 until the commit, then `score`=2.
- `game_over`, then an add of 9 in OVER -> `frozen`=1 and `score` unchanged. `clear` -> `frozen`=0 and adds are accepted again.
- With `SCORE_HISCORE_EN`:
  - `score` reaches 30, then `clear`, then 10 points are added and committed;
  - `hiscore` stays 30 and `score` is 10;
  - `rst` -> `hiscore`=0.
